// File: rtl/alu_control_seq.sv
// ALU control decoder with a valid/ready request side, a multi-cycle hold for MULT/DIV
// and a registered result held until the consumer takes it.
// state | meaning
// IDLE  | ready for a request
// MC    | multi-cycle op counting down
// OUT   | result valid, waiting for out_ready
module alu_control_seq #(
    parameter int OPW       = 3,
    parameter int FW        = 6,
    parameter int CW        = 4,
    parameter int MC_CYCLES = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [OPW-1:0] ALUop,
    input  logic [FW-1:0]  function_code,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [CW-1:0]  alu_ctr,
    output logic           illegal,
    output logic           mc_busy,
    output logic [7:0]     mc_count
);

    generate
        if (CW < OPW) begin : g_bad_cw
            $error("alu_control_seq: CW must be >= OPW");
        end
        if (MC_CYCLES < 2 || MC_CYCLES > 255) begin : g_bad_mc
            $error("alu_control_seq: MC_CYCLES must be in 2..255");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MC   = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    localparam logic [OPW-1:0] RTYPE   = '1;
    localparam logic [7:0]     MC_INIT = 8'(MC_CYCLES - 1);

    state_t          state, state_nx;
    logic [CW-1:0]   alu_ctr_nx;
    logic            illegal_nx;
    logic [7:0]      mc_count_nx;
    logic [CW-1:0]   dec_ctr;
    logic            dec_illegal;
    logic            dec_multi;

    // Combinational decode of the presented request; only captured on accept.
    always_comb begin
        dec_ctr     = '0;
        dec_illegal = 1'b0;
        dec_multi   = 1'b0;
        if (ALUop != RTYPE) begin
            dec_ctr = CW'(ALUop);
        end else begin
            case (function_code)
                FW'(6'h20): dec_ctr = CW'(4'b0010);
                FW'(6'h22): dec_ctr = CW'(4'b0110);
                FW'(6'h24): dec_ctr = CW'(4'b0000);
                FW'(6'h25): dec_ctr = CW'(4'b0001);
                FW'(6'h27): dec_ctr = CW'(4'b1100);
                FW'(6'h2A): dec_ctr = CW'(4'b0111);
                FW'(6'h00): dec_ctr = CW'(4'b1000);
                FW'(6'h02): dec_ctr = CW'(4'b1001);
                FW'(6'h18): begin
                    dec_ctr   = CW'(4'b1010);
                    dec_multi = 1'b1;
                end
                FW'(6'h1A): begin
                    dec_ctr   = CW'(4'b1011);
                    dec_multi = 1'b1;
                end
                default: begin
                    dec_ctr     = '1;
                    dec_illegal = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        state_nx    = state;
        alu_ctr_nx  = alu_ctr;
        illegal_nx  = illegal;
        mc_count_nx = mc_count;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    alu_ctr_nx = dec_ctr;
                    illegal_nx = dec_illegal;
                    if (dec_multi) begin
                        state_nx    = S_MC;
                        mc_count_nx = MC_INIT;
                    end else begin
                        state_nx = S_OUT;
                    end
                end
            end
            S_MC: begin
                if (mc_count == 8'd1) begin
                    mc_count_nx = 8'd0;
                    state_nx    = S_OUT;
                end else begin
                    mc_count_nx = mc_count - 8'd1;
                end
            end
            S_OUT: begin
                if (out_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            alu_ctr  <= '0;
            illegal  <= 1'b0;
            mc_count <= 8'd0;
        end else begin
            state    <= state_nx;
            alu_ctr  <= alu_ctr_nx;
            illegal  <= illegal_nx;
            mc_count <= mc_count_nx;
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_OUT);
    assign mc_busy   = (state == S_MC);

endmodule

// File: doc/alu_control_seq.md
ALU_CONTROL_SEQ -- requirements
Module: alu_control_seq

Interface
REQ-001 Parameter OPW, default 3: width of ALUop; all-ones value selects R-type decode.
REQ-002 Parameter FW, default 6: width of function_code.
REQ-003 Parameter CW, default 4: width of alu_ctr; CW >= OPW SHALL hold (elaboration error otherwise).
REQ-004 Parameter MC_CYCLES, default 32: cycle count of a multi-cycle op, legal range 2..255.
REQ-005 Single clock; reset is synchronous and active-high.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 in_valid  in  1  request present.
REQ-009 in_ready  out  1  block can accept a request.
REQ-010 ALUop  in  OPW  main-control op.
REQ-011 function_code  in  FW  R-type funct field.
REQ-012 out_valid  out  1  alu_ctr/illegal valid.
REQ-013 out_ready  in  1  consumer takes result.
REQ-014 alu_ctr  out  CW  registered ALU control code.
REQ-015 illegal  out  1  R-type funct not in table.
REQ-016 mc_busy  out  1  multi-cycle op in progress.
REQ-017 mc_count  out  8  remaining multi-cycle count.

Function
REQ-018 Transfer occurs on a rising edge with in_valid && in_ready; in_ready SHALL be 1 only in IDLE.
REQ-019 Non-R-type (ALUop != all-ones): alu_ctr SHALL be ALUop zero-extended to CW, illegal=0, single-cycle.
REQ-020 R-type table (funct -> alu_ctr): 0x20 ADD 0010, 0x22 SUB 0110, 0x24 AND 0000, 0x25 OR 0001, 0x27 NOR 1100, 0x2A SLT 0111, 0x00 SLL 1000, 0x02 SRL 1001, 0x18 MULT 1010, 0x1A DIV 1011.
REQ-021 Any other R-type funct SHALL give alu_ctr=all-ones, illegal=1, single-cycle.
REQ-022 MULT and DIV are multi-cycle; all other codes are single-cycle.
REQ-023 States: IDLE, MC, OUT; decode and alu_ctr/illegal SHALL be captured on the accept edge and held stable until the OUT handshake completes.
REQ-024 IDLE: on accept of a single-cycle op go to OUT; of a multi-cycle op go to MC with mc_count=MC_CYCLES-1.
REQ-025 MC: mc_busy=1; mc_count decrements by 1 per cycle; on the edge where mc_count==1, load 0 and go to OUT.
REQ-026 OUT: out_valid=1; on out_ready=1 go to IDLE; otherwise hold all outputs unchanged.
REQ-027 Latency: single-cycle op out_valid the cycle after accept; multi-cycle op out_valid MC_CYCLES cycles after accept.
REQ-028 out_valid SHALL be 0 in IDLE and MC; mc_busy SHALL be 0 in IDLE and OUT.
REQ-029 in_valid while not IDLE SHALL be ignored (no capture, no state change); out_ready outside OUT SHALL be ignored.
REQ-030 No accept in the OUT->IDLE handshake cycle; next request is accepted earliest one cycle later (one transaction per >= 2 cycles).
REQ-031 mc_count is 0 outside MC.

Reset
REQ-032 reset=1 on a rising edge SHALL force IDLE, in_ready=1, out_valid=0, mc_busy=0, mc_count=0, alu_ctr=0, illegal=0, overriding any other input, including mid-MC or mid-OUT.
REQ-033 reset SHALL have no asynchronous effect; outputs change only on clk edges.

Verification
REQ-034 reset 2 cycles, then ALUop=3'b010 accepted, out_ready=1 -> next cycle out_valid=1, alu_ctr=4'b0010, illegal=0; then IDLE, in_ready=1.
REQ-035 ALUop=3'b111, funct=0x2A, out_ready=0 for 3 cycles -> out_valid=1, alu_ctr=4'b0111 held stable 3 cycles; in_valid pulses meanwhile ignored.
REQ-036 ALUop=3'b111, funct=0x18, MC_CYCLES=32 -> mc_busy=1 for 31 cycles, mc_count 31..1, out_valid at cycle 32 after accept with alu_ctr=4'b1010.
REQ-037 ALUop=3'b111, funct=0x3F -> alu_ctr=4'b1111, illegal=1, single-cycle latency.
REQ-038 reset asserted at mc_count=10 during DIV -> next cycle IDLE, all outputs at reset values; a following ADD completes normally.
REQ-039 Re-run REQ-034..037 with OPW=4, CW=6, MC_CYCLES=2: R-type select at ALUop=4'b1111, codes zero-extended, MULT out_valid 2 cycles after accept.
